// File: rtl/roberto_pkg.sv
// Shared encodings for the roberto_uc measure/transmit controller:
// FSM state codes, serial-mux sensor codes and digit-select codes.
package roberto_pkg;

  typedef enum logic [3:0] {
    StInicial   = 4'd0,
    StPrepara   = 4'd1,
    StMede      = 4'd2,
    StAguarda   = 4'd3,
    StTransmite = 4'd4,
    StEsperaTx  = 4'd5,
    StProximo   = 4'd6,
    StIntervalo = 4'd7,
    StFim       = 4'd8
  } estado_t;

  // sel_medida codes
  localparam logic [1:0] SelNenhum = 2'd0;
  localparam logic [1:0] SelSens3  = 2'd1;
  localparam logic [1:0] SelSens2  = 2'd2;
  localparam logic [1:0] SelSens1  = 2'd3;

  // sel_sensK codes: 3 hundreds, 2 tens, 1 units, 0 '#'
  localparam logic [1:0] DigHash    = 2'd0;
  localparam logic [1:0] DigCentena = 2'd3;

  localparam logic [3:0] UltimoChar = 4'd11;

  // Char index idx: idx[3:2] picks the sensor (0..2), idx[1:0] the position inside its group.
  function automatic logic [1:0] sel_medida_de(logic [3:0] idx);
    return SelSens1 - idx[3:2];
  endfunction

  function automatic logic [1:0] digito_de(logic [3:0] idx);
    return DigCentena - idx[1:0];
  endfunction

endpackage

// File: rtl/roberto_uc_if.sv
// Handshake bundle between roberto_uc (master) and its sensor/serial datapath (slave).
interface roberto_uc_if;
  logic       ligar;
  logic       pronto_medida1;
  logic       pronto_medida2;
  logic       pronto_medida3;
  logic       pronto_serial;
  logic       zera_sensor;
  logic       zera_serial;
  logic       medir;
  logic [1:0] sel_sens1;
  logic [1:0] sel_sens2;
  logic [1:0] sel_sens3;
  logic [1:0] sel_medida;
  logic       partida_tx;
  logic       pronto;
  logic [3:0] db_estado;
  logic       db_timeout;

  modport master (
    input  ligar, pronto_medida1, pronto_medida2, pronto_medida3, pronto_serial,
    output zera_sensor, zera_serial, medir, sel_sens1, sel_sens2, sel_sens3, sel_medida,
           partida_tx, pronto, db_estado, db_timeout
  );

  modport slave (
    output ligar, pronto_medida1, pronto_medida2, pronto_medida3, pronto_serial,
    input  zera_sensor, zera_serial, medir, sel_sens1, sel_sens2, sel_sens3, sel_medida,
           partida_tx, pronto, db_estado, db_timeout
  );
endinterface

// File: rtl/contador_m.sv
// Modulo-M counter with synchronous clear and enable; fim_o flags the terminal count M-1.
module contador_m #(
  parameter int unsigned M = 100
) (
  input  logic clock,
  input  logic reset,
  input  logic zera_i,
  input  logic conta_i,
  output logic fim_o
);

  localparam int unsigned W = (M > 1) ? $clog2(M) : 1;

  logic [W-1:0] q_q, q_d;

  assign fim_o = (q_q == W'(M - 1));

  always_comb begin
    q_d = q_q;
    if (zera_i) begin
      q_d = '0;
    end else if (conta_i) begin
      q_d = fim_o ? '0 : q_q + W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

endmodule

// File: rtl/roberto_uc.sv
// Control unit: measure three sensors, send 12 characters, wait INTERVALO cycles, repeat.
// Optional AGUARDA timeout enabled by defining ROBERTO_UC_TIMEOUT_EN.
module roberto_uc
  import roberto_pkg::*;
#(
  parameter int unsigned INTERVALO = 50_000_000,
  parameter int unsigned TIMEOUT   = 3_000_000
) (
  input  logic         clock,
  input  logic         reset,
  roberto_uc_if.master bus
);

  estado_t    state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [2:0] flags_q, flags_d;
  logic [2:0] pulsos;
  logic       captura, todos, intervalo_fim, timeout_fim;

  logic       zera_q, medir_q, partida_q, pronto_q;
  logic [1:0] sel_medida_q, sel1_q, sel2_q, sel3_q;
  logic [1:0] sel_medida_d, sel1_d, sel2_d, sel3_d;
  logic       envia_d;
  logic       db_timeout_q;

  assign pulsos  = {bus.pronto_medida3, bus.pronto_medida2, bus.pronto_medida1};
  assign captura = (state_q == StMede) || (state_q == StAguarda);
  // Include this cycle's pulses so the jump happens right after the last one arrives.
  assign todos   = &(flags_q | pulsos);

  contador_m #(.M(INTERVALO)) u_cont_intervalo (
    .clock   (clock),
    .reset   (reset),
    .zera_i  (state_q != StIntervalo),
    .conta_i (state_q == StIntervalo),
    .fim_o   (intervalo_fim)
  );

`ifdef ROBERTO_UC_TIMEOUT_EN
  contador_m #(.M(TIMEOUT)) u_cont_timeout (
    .clock   (clock),
    .reset   (reset),
    .zera_i  (state_q != StAguarda),
    .conta_i (state_q == StAguarda),
    .fim_o   (timeout_fim)
  );
`else
  // Keeps TIMEOUT referenced when the timeout feature is compiled out.
  assign timeout_fim = 1'b0 & (TIMEOUT != 0);
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    flags_d = flags_q;
    if (captura) begin
      flags_d = flags_q | pulsos;
    end
    case (state_q)
      StInicial: if (bus.ligar) state_d = StPrepara;
      StPrepara: begin
        flags_d = '0;
        idx_d   = '0;
        state_d = StMede;
      end
      StMede:      state_d = StAguarda;
      StAguarda:   if (todos || timeout_fim) state_d = StTransmite;
      StTransmite: state_d = StEsperaTx;
      StEsperaTx:  if (bus.pronto_serial) state_d = StProximo;
      StProximo: begin
        if (idx_q == UltimoChar) begin
          idx_d   = '0;
          state_d = StFim;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = StTransmite;
        end
      end
      StFim: state_d = StIntervalo;
      StIntervalo: begin
        flags_d = '0;
        if (intervalo_fim) state_d = bus.ligar ? StMede : StInicial;
      end
      default: state_d = StInicial;
    endcase
  end

  // Select lines are driven only while a character is in flight.
  always_comb begin
    envia_d      = (state_d == StTransmite) || (state_d == StEsperaTx);
    sel_medida_d = envia_d ? sel_medida_de(idx_d) : SelNenhum;
    sel1_d       = (sel_medida_d == SelSens1) ? digito_de(idx_d) : DigHash;
    sel2_d       = (sel_medida_d == SelSens2) ? digito_de(idx_d) : DigHash;
    sel3_d       = (sel_medida_d == SelSens3) ? digito_de(idx_d) : DigHash;
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= StInicial;
      idx_q        <= '0;
      flags_q      <= '0;
      zera_q       <= 1'b0;
      medir_q      <= 1'b0;
      partida_q    <= 1'b0;
      pronto_q     <= 1'b0;
      sel_medida_q <= SelNenhum;
      sel1_q       <= DigHash;
      sel2_q       <= DigHash;
      sel3_q       <= DigHash;
      db_timeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      flags_q      <= flags_d;
      zera_q       <= (state_d == StPrepara);
      medir_q      <= (state_d == StMede);
      partida_q    <= (state_d == StTransmite);
      pronto_q     <= (state_d == StFim);
      sel_medida_q <= sel_medida_d;
      sel1_q       <= sel1_d;
      sel2_q       <= sel2_d;
      sel3_q       <= sel3_d;
`ifdef ROBERTO_UC_TIMEOUT_EN
      if (state_d == StPrepara) begin
        db_timeout_q <= 1'b0;
      end else if ((state_q == StAguarda) && timeout_fim && !todos) begin
        db_timeout_q <= 1'b1;
      end
`else
      db_timeout_q <= 1'b0;
`endif
    end
  end

  assign bus.zera_sensor = zera_q;
  assign bus.zera_serial = zera_q;
  assign bus.medir       = medir_q;
  assign bus.partida_tx  = partida_q;
  assign bus.pronto      = pronto_q;
  assign bus.sel_medida  = sel_medida_q;
  assign bus.sel_sens1   = sel1_q;
  assign bus.sel_sens2   = sel2_q;
  assign bus.sel_sens3   = sel3_q;
  assign bus.db_estado   = state_q;
  assign bus.db_timeout  = db_timeout_q;

endmodule

// File: tb/tb_roberto_uc.sv
// Directed self-checking bench for roberto_uc (INTERVALO=20, TIMEOUT=100).
module tb_roberto_uc;

  localparam int unsigned Intervalo = 20;
  localparam int unsigned Timeout   = 100;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  // {sel_medida, sel_sens1, sel_sens2, sel_sens3} for characters 0..11
  logic [7:0] exp_sel [12] = '{8'hF0, 8'hE0, 8'hD0, 8'hC0, 8'h8C, 8'h88, 8'h84, 8'h80,
                               8'h43, 8'h42, 8'h41, 8'h40};

  roberto_uc_if bus ();

  roberto_uc #(.INTERVALO(Intervalo), .TIMEOUT(Timeout)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [7:0] sel_obs();
    return {bus.sel_medida, bus.sel_sens1, bus.sel_sens2, bus.sel_sens3};
  endfunction

  function automatic logic [10:0] all_outs();
    return {bus.zera_sensor, bus.zera_serial, bus.medir, bus.partida_tx, bus.pronto,
            bus.db_timeout, bus.sel_medida != 2'd0, bus.sel_sens1 != 2'd0,
            bus.sel_sens2 != 2'd0, bus.sel_sens3 != 2'd0, bus.db_estado != 4'd0};
  endfunction

  // Starts in the TRANSMITE cycle of char 0, ends in the FIM cycle.
  task automatic tx_round(input string tag, input int drop_at);
    for (int i = 0; i < 12; i++) begin
      if (i == drop_at) bus.ligar = 1'b0;
      n_vec++;
      if ({bus.db_estado, bus.partida_tx} !== {4'd4, 1'b1}) begin
        n_err++;
        $display("FAIL %s_tx%0d_start: got estado=%0d partida=%0b want estado=4 partida=1",
                 tag, i, bus.db_estado, bus.partida_tx);
      end
      n_vec++;
      if (sel_obs() !== exp_sel[i]) begin
        n_err++;
        $display("FAIL %s_tx%0d_sel: got %h want %h", tag, i, sel_obs(), exp_sel[i]);
      end
      if (i == 2) bus.pronto_serial = 1'b1;  // stray pulse in TRANSMITE must be ignored
      step();
      bus.pronto_serial = 1'b0;
      for (int w = 0; w < 3; w++) begin
        n_vec++;
        if ({bus.db_estado, bus.partida_tx, sel_obs()} !== {4'd5, 1'b0, exp_sel[i]}) begin
          n_err++;
          $display("FAIL %s_tx%0d_wait%0d: got estado=%0d partida=%0b sel=%h want 5 0 %h",
                   tag, i, w, bus.db_estado, bus.partida_tx, sel_obs(), exp_sel[i]);
        end
        if (w < 2) step();
      end
      bus.pronto_serial = 1'b1;
      step();
      bus.pronto_serial = 1'b0;
      n_vec++;
      if (bus.db_estado !== 4'd6) begin
        n_err++;
        $display("FAIL %s_tx%0d_proximo: got estado=%0d want 6", tag, i, bus.db_estado);
      end
      step();
    end
    n_vec++;
    if ({bus.db_estado, bus.pronto} !== {4'd8, 1'b1}) begin
      n_err++;
      $display("FAIL %s_fim: got estado=%0d pronto=%0b want estado=8 pronto=1",
               tag, bus.db_estado, bus.pronto);
    end
  endtask

  // Starts in FIM; ends in MEDE (expect_mede) or INICIAL, 21 cycles after the pronto pulse.
  task automatic interval_check(input string tag, input bit expect_mede);
    for (int c = 1; c <= 20; c++) begin
      step();
      bus.pronto_medida1 = (c == 5);
      bus.pronto_medida2 = (c == 5);
      bus.pronto_medida3 = (c == 5);
      n_vec++;
      if ({bus.db_estado, bus.medir, bus.pronto} !== {4'd7, 1'b0, 1'b0}) begin
        n_err++;
        $display("FAIL %s_intervalo%0d: got estado=%0d medir=%0b pronto=%0b want 7 0 0",
                 tag, c, bus.db_estado, bus.medir, bus.pronto);
      end
    end
    step();
    n_vec++;
    if (expect_mede && ({bus.db_estado, bus.medir} !== {4'd2, 1'b1})) begin
      n_err++;
      $display("FAIL %s_remede: got estado=%0d medir=%0b want estado=2 medir=1",
               tag, bus.db_estado, bus.medir);
    end else if (!expect_mede && ({bus.db_estado, bus.medir} !== {4'd0, 1'b0})) begin
      n_err++;
      $display("FAIL %s_inicial: got estado=%0d medir=%0b want estado=0 medir=0",
               tag, bus.db_estado, bus.medir);
    end
  endtask

  task automatic check_prepara_mede(input string tag);
    step();
    n_vec++;
    if ({bus.db_estado, bus.zera_sensor, bus.zera_serial, bus.medir} !== {4'd1, 3'b110}) begin
      n_err++;
      $display("FAIL %s_prepara: got estado=%0d zera=%0b%0b medir=%0b want 1 11 0", tag,
               bus.db_estado, bus.zera_sensor, bus.zera_serial, bus.medir);
    end
    step();
    n_vec++;
    if ({bus.db_estado, bus.zera_sensor, bus.zera_serial, bus.medir} !== {4'd2, 3'b001}) begin
      n_err++;
      $display("FAIL %s_mede: got estado=%0d zera=%0b%0b medir=%0b want 2 00 1", tag,
               bus.db_estado, bus.zera_sensor, bus.zera_serial, bus.medir);
    end
  endtask

  task automatic test_reset();
    bus.ligar = 1'b0;
    bus.pronto_medida1 = 1'b0;
    bus.pronto_medida2 = 1'b0;
    bus.pronto_medida3 = 1'b0;
    bus.pronto_serial  = 1'b0;
    #3;
    n_vec++;
    if (all_outs() !== 11'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b want 0", all_outs());
    end
    step();
    reset = 1'b1;
    step();
    n_vec++;
    if ({bus.db_estado, bus.db_timeout} !== {4'd0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_idle: got estado=%0d timeout=%0b want 0 0",
               bus.db_estado, bus.db_timeout);
    end
  endtask

  // Sensors answer 10/20/30 cycles after medir; ligar held, so the next round re-measures.
  task automatic test_staggered_round();
    bus.ligar = 1'b1;
    check_prepara_mede("stag");
    for (int c = 1; c <= 30; c++) begin
      step();
      n_vec++;
      if ({bus.db_estado, bus.medir, bus.partida_tx} !== {4'd3, 2'b00}) begin
        n_err++;
        $display("FAIL stag_aguarda%0d: got estado=%0d medir=%0b partida=%0b want 3 0 0",
                 c, bus.db_estado, bus.medir, bus.partida_tx);
      end
      bus.pronto_medida1 = (c == 10);
      bus.pronto_medida2 = (c == 20);
      bus.pronto_medida3 = (c == 30);
    end
    step();
    bus.pronto_medida3 = 1'b0;
    tx_round("stag", -1);
    interval_check("stag", 1'b1);
  endtask

  // Starts in MEDE; all three results in one cycle, then ligar drops at char 5.
  task automatic test_same_cycle_drop();
    step();
    n_vec++;
    if (bus.db_estado !== 4'd3) begin
      n_err++;
      $display("FAIL same_aguarda: got estado=%0d want 3", bus.db_estado);
    end
    bus.pronto_medida1 = 1'b1;
    bus.pronto_medida2 = 1'b1;
    bus.pronto_medida3 = 1'b1;
    step();
    bus.pronto_medida1 = 1'b0;
    bus.pronto_medida2 = 1'b0;
    bus.pronto_medida3 = 1'b0;
    tx_round("same", 5);
    interval_check("drop", 1'b0);
    step();
    n_vec++;
    if (bus.db_estado !== 4'd0) begin
      n_err++;
      $display("FAIL drop_stays_idle: got estado=%0d want 0", bus.db_estado);
    end
  endtask

  task automatic test_reset_mid_tx();
    bus.ligar = 1'b1;
    check_prepara_mede("rst");
    step();
    bus.pronto_medida1 = 1'b1;
    bus.pronto_medida2 = 1'b1;
    bus.pronto_medida3 = 1'b1;
    step();
    bus.pronto_medida1 = 1'b0;
    bus.pronto_medida2 = 1'b0;
    bus.pronto_medida3 = 1'b0;
    step();
    n_vec++;
    if ({bus.db_estado, sel_obs()} !== {4'd5, 8'hF0}) begin
      n_err++;
      $display("FAIL rst_pre_espera: got estado=%0d sel=%h want 5 f0", bus.db_estado, sel_obs());
    end
    reset = 1'b0;
    #1;
    n_vec++;
    if (all_outs() !== 11'd0) begin
      n_err++;
      $display("FAIL rst_async_outputs: got %b want 0", all_outs());
    end
    step();
    step();
    reset = 1'b1;
    #1;
    n_vec++;
    if (bus.db_estado !== 4'd0) begin
      n_err++;
      $display("FAIL rst_release_hold: got estado=%0d want 0", bus.db_estado);
    end
    @(posedge clock);
    #1;
    n_vec++;
    if ({bus.db_estado, bus.zera_sensor} !== {4'd1, 1'b1}) begin
      n_err++;
      $display("FAIL rst_restart_prepara: got estado=%0d zera=%0b want 1 1",
               bus.db_estado, bus.zera_sensor);
    end
    step();
    n_vec++;
    if ({bus.db_estado, bus.medir} !== {4'd2, 1'b1}) begin
      n_err++;
      $display("FAIL rst_restart_mede: got estado=%0d medir=%0b want 2 1",
               bus.db_estado, bus.medir);
    end
    step();
    bus.pronto_medida2 = 1'b1;
    bus.pronto_medida3 = 1'b1;
    step();
    bus.pronto_medida2 = 1'b0;
    bus.pronto_medida3 = 1'b0;
    bus.pronto_medida1 = 1'b1;
    n_vec++;
    if (bus.db_estado !== 4'd3) begin
      n_err++;
      $display("FAIL rst_partial_flags: got estado=%0d want 3", bus.db_estado);
    end
    step();
    bus.pronto_medida1 = 1'b0;
    tx_round("rst", 11);
    interval_check("rst", 1'b0);
  endtask

`ifdef ROBERTO_UC_TIMEOUT_EN
  task automatic test_timeout();
    bus.ligar = 1'b1;
    check_prepara_mede("tmo");
    for (int c = 1; c <= 100; c++) begin
      step();
      bus.pronto_medida1 = (c == 1);
      n_vec++;
      if ({bus.db_estado, bus.db_timeout} !== {4'd3, 1'b0}) begin
        n_err++;
        $display("FAIL tmo_aguarda%0d: got estado=%0d timeout=%0b want 3 0",
                 c, bus.db_estado, bus.db_timeout);
      end
    end
    step();
    n_vec++;
    if ({bus.db_estado, bus.db_timeout} !== {4'd4, 1'b1}) begin
      n_err++;
      $display("FAIL tmo_expire: got estado=%0d timeout=%0b want 4 1",
               bus.db_estado, bus.db_timeout);
    end
    tx_round("tmo", 0);
    interval_check("tmo", 1'b0);
    n_vec++;
    if (bus.db_timeout !== 1'b1) begin
      n_err++;
      $display("FAIL tmo_sticky: got %0b want 1", bus.db_timeout);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_staggered_round();
    test_same_cycle_drop();
    test_reset_mid_tx();
`ifdef ROBERTO_UC_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
